// File: rtl/oob_pkg.sv
// Shared OOB host definitions: FSM states, primitive words, retry limit and the
// received-word classifier used by the primitive detector.
package oob_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_COMRESET,
    ST_AWAIT_COMINIT,
    ST_AWAIT_NOCOMINIT,
    ST_COMWAKE,
    ST_AWAIT_COMWAKE,
    ST_AWAIT_NOCOMWAKE,
    ST_AWAIT_ALIGN,
    ST_SEND_ALIGN,
    ST_READY,
    ST_ERROR
  } oob_state_t;

  typedef enum logic [1:0] {
    PRIM_NONE,
    PRIM_ALIGN,
    PRIM_SYNC
  } prim_t;

  localparam logic [31:0] ALIGNP      = 32'h7B4A4ABC;
  localparam logic [31:0] SYNCP       = 32'hB5B5957C;
  localparam logic [31:0] D10_2       = 32'h4A4A4A4A;
  localparam logic [3:0]  K_PRIM      = 4'h1;
  localparam logic [3:0]  K_DATA      = 4'h0;
  localparam int unsigned RETRY_LIMIT = 4;

  function automatic prim_t classify(input logic [31:0] data, input logic [3:0] k);
    prim_t p;
    p = PRIM_NONE;
    if (k == K_PRIM && data == ALIGNP) p = PRIM_ALIGN;
    else if (k == K_PRIM && data == SYNCP) p = PRIM_SYNC;
    return p;
  endfunction

endpackage

// File: rtl/oob_prim_det.sv
// Registered ALIGNp/SYNCp classifier of the receive word plus the run counter
// of consecutive non-ALIGNp words used to leave SEND_ALIGN.
module oob_prim_det
  import oob_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_charisk,
  input  logic        count_en,
  output prim_t       prim,
  output logic        non_align_3
);

  logic [1:0] run;

  always_ff @(posedge clk) begin
    if (rst) begin
      prim <= PRIM_NONE;
      run  <= '0;
    end else begin
      prim <= classify(rx_data, rx_charisk);
      if (!count_en || prim == PRIM_ALIGN) run <= '0;
      else if (run != 2'd3)                run <= run + 2'd1;
    end
  end

  // Third consecutive non-ALIGNp word is the one being looked at right now.
  assign non_align_3 = count_en && (prim != PRIM_ALIGN) && (run == 2'd2);

endmodule

// File: rtl/oob_host_ctrl.sv
// SATA host OOB sequencer: COMRESET/COMINIT, COMWAKE, ALIGNp handshake, READY.
// Optional macro OOB_HOST_LINKDOWN_EN: leave READY after 16 cycles of rx electrical idle.
module oob_host_ctrl
  import oob_pkg::*;
#(
  parameter int CLK_SPEED_GRADE      = 2,
  parameter int RETRY_CYCLES         = 1000,
  parameter int NOSIG_CYCLES         = 38,
  parameter int ALIGN_TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gtx_ready,
  input  logic        oob_start,
  input  logic        rxcominitdet_in,
  input  logic        rxcomwakedet_in,
  input  logic        rxelecidle_in,
  input  logic [31:0] rxdata_in,
  input  logic [3:0]  rxcharisk_in,
  output logic        txcominit,
  output logic        txcomwake,
  output logic        txelecidle,
  output logic [31:0] txdata_out,
  output logic [3:0]  txcharisk_out,
  output logic        link_up,
  output logic        oob_busy,
  output logic        oob_error,
  output logic        oob_silence
);

  localparam int TMAX_A = (RETRY_CYCLES > NOSIG_CYCLES) ? RETRY_CYCLES : NOSIG_CYCLES;
  localparam int TMAX   = (TMAX_A > ALIGN_TIMEOUT_CYCLES) ? TMAX_A : ALIGN_TIMEOUT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RETRY_LAST = TW'(RETRY_CYCLES - 1);
  localparam logic [TW-1:0] NOSIG_LAST = TW'(NOSIG_CYCLES - 1);
  localparam logic [TW-1:0] ALIGN_LAST = TW'(ALIGN_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX  = 3'(RETRY_LIMIT - 1);

  logic          cominit_q, comwake_q, elecidle_q;
  oob_state_t    state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    retry, retry_next;
  logic          silence_q, silence_next;
  prim_t         prim;
  logic          non_align_3;
  logic          linkdown;
  logic          unused_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      cominit_q  <= 1'b0;
      comwake_q  <= 1'b0;
      elecidle_q <= 1'b0;
    end else begin
      cominit_q  <= rxcominitdet_in;
      comwake_q  <= rxcomwakedet_in;
      elecidle_q <= rxelecidle_in;
    end
  end

  oob_prim_det u_prim_det (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rxdata_in),
    .rx_charisk  (rxcharisk_in),
    .count_en    (state == ST_SEND_ALIGN),
    .prim        (prim),
    .non_align_3 (non_align_3)
  );

`ifdef OOB_HOST_LINKDOWN_EN
  logic [3:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst)                                idle_cnt <= '0;
    else if (state == ST_READY && elecidle_q) idle_cnt <= idle_cnt + 4'd1;
    else                                    idle_cnt <= '0;
  end

  assign linkdown  = (state == ST_READY) && elecidle_q && (idle_cnt == 4'd15);
  assign unused_ok = (CLK_SPEED_GRADE == 0);
`else
  assign linkdown  = 1'b0;
  assign unused_ok = (CLK_SPEED_GRADE == 0) ^ elecidle_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      retry     <= '0;
      silence_q <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      retry     <= retry_next;
      silence_q <= silence_next;
    end
  end

  always_comb begin
    state_next   = state;
    timer_next   = timer + TW'(1);
    retry_next   = retry;
    silence_next = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_next = '0;
        retry_next = '0;
        if (oob_start) state_next = ST_COMRESET;
      end
      // Timer keeps running into AWAIT_COMINIT so re-issues are RETRY_CYCLES apart.
      ST_COMRESET: state_next = ST_AWAIT_COMINIT;
      ST_AWAIT_COMINIT: begin
        if (cominit_q) begin
          state_next = ST_AWAIT_NOCOMINIT;
          timer_next = '0;
          retry_next = '0;
        end else if (timer == RETRY_LAST) begin
          timer_next = '0;
          if (retry == RETRY_MAX) begin
            state_next   = ST_IDLE;
            retry_next   = '0;
            silence_next = 1'b1;
          end else begin
            state_next = ST_COMRESET;
            retry_next = retry + 3'd1;
          end
        end
      end
      ST_AWAIT_NOCOMINIT: begin
        if (cominit_q) timer_next = '0;
        else if (timer == NOSIG_LAST) begin
          state_next = ST_COMWAKE;
          timer_next = '0;
        end
      end
      ST_COMWAKE: begin
        state_next = ST_AWAIT_COMWAKE;
        timer_next = '0;
      end
      ST_AWAIT_COMWAKE: begin
        if (comwake_q) begin
          state_next = ST_AWAIT_NOCOMWAKE;
          timer_next = '0;
        end else if (timer == RETRY_LAST) begin
          state_next = ST_ERROR;
          timer_next = '0;
        end
      end
      ST_AWAIT_NOCOMWAKE: begin
        if (comwake_q) timer_next = '0;
        else if (timer == NOSIG_LAST) begin
          state_next = ST_AWAIT_ALIGN;
          timer_next = '0;
        end
      end
      ST_AWAIT_ALIGN: begin
        if (prim == PRIM_ALIGN) begin
          state_next = ST_SEND_ALIGN;
          timer_next = '0;
        end else if (timer == ALIGN_LAST) begin
          state_next = ST_ERROR;
          timer_next = '0;
        end
      end
      ST_SEND_ALIGN: begin
        timer_next = '0;
        if (non_align_3) state_next = ST_READY;
      end
      ST_READY: begin
        timer_next = '0;
        retry_next = '0;
        if (oob_start || linkdown) state_next = ST_COMRESET;
      end
      ST_ERROR: begin
        timer_next = '0;
        retry_next = '0;
        state_next = ST_COMRESET;
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
        retry_next = '0;
      end
    endcase
    if (!gtx_ready) begin
      state_next   = ST_IDLE;
      timer_next   = '0;
      retry_next   = '0;
      silence_next = 1'b0;
    end
  end

  always_comb begin
    txcominit     = 1'b0;
    txcomwake     = 1'b0;
    txelecidle    = 1'b1;
    txdata_out    = '0;
    txcharisk_out = K_DATA;
    link_up       = 1'b0;
    oob_error     = 1'b0;
    oob_silence   = silence_q;
    oob_busy      = (state != ST_IDLE) && (state != ST_READY);
    case (state)
      ST_COMRESET: txcominit = 1'b1;
      ST_COMWAKE:  txcomwake = 1'b1;
      ST_ERROR:    oob_error = 1'b1;
      ST_AWAIT_ALIGN: begin
        txelecidle = 1'b0;
        txdata_out = D10_2;
      end
      ST_SEND_ALIGN: begin
        txelecidle    = 1'b0;
        txdata_out    = ALIGNP;
        txcharisk_out = K_PRIM;
      end
      ST_READY: begin
        txelecidle    = 1'b0;
        txdata_out    = SYNCP;
        txcharisk_out = K_PRIM;
        link_up       = 1'b1;
      end
      default: ;
    endcase
    // Reset and transceiver loss silence the outputs in the same cycle.
    if (rst || !gtx_ready) begin
      txcominit     = 1'b0;
      txcomwake     = 1'b0;
      txelecidle    = 1'b1;
      txdata_out    = '0;
      txcharisk_out = '0;
      link_up       = 1'b0;
      oob_busy      = 1'b0;
      oob_error     = 1'b0;
      oob_silence   = 1'b0;
    end
  end

endmodule
